// File: rtl/id_inst_buffer_if.sv
// rtl/id_inst_buffer_if.sv - fetch/decode side signals of the instruction buffer
interface id_inst_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic                     flush;
  logic                     push_valid;
  logic                     push_ready;
  logic [ADDR_W-1:0]        push_addr;
  logic [INST_W-1:0]        push_inst;
  logic                     pop_valid;
  logic                     pop_ready;
  logic [ADDR_W-1:0]        pop_addr;
  logic [INST_W-1:0]        pop_inst;
  logic                     pop_delayslot;
  logic                     branch_taken;
  logic [$clog2(DEPTH):0]   count;

  // Fetch/decode pipeline side
  modport master (
    output flush, push_valid, push_addr, push_inst, pop_ready, branch_taken,
    input  push_ready, pop_valid, pop_addr, pop_inst, pop_delayslot, count
  );

  // Buffer side
  modport slave (
    input  flush, push_valid, push_addr, push_inst, pop_ready, branch_taken,
    output push_ready, pop_valid, pop_addr, pop_inst, pop_delayslot, count
  );
endinterface

// File: rtl/id_inst_buffer.sv
// rtl/id_inst_buffer.sv - IF-to-ID instruction FIFO with delay-slot squash and flush
module id_inst_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input logic             clk,
  input logic             rst,
  id_inst_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [DEPTH-1:0]  tag_mem;

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_next;
  logic [PTR_W-1:0]  rd_next2;
  logic [PTR_W-1:0]  wr_next;
  logic [CNT_W-1:0]  count_q;
  logic              ds_pending;

  logic              full;
  logic              empty;
  logic              push_fire;
  logic              pop_fire;
  logic              branch_fire;
  logic              keep_queued;
  logic              wr_en;
  logic              wr_tag;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign push_fire   = bus.push_valid & ~full;
  assign pop_fire    = ~empty & bus.pop_ready;
  assign branch_fire = pop_fire & bus.branch_taken & ~bus.flush;
  // The instruction right behind the branch is already queued: it becomes the
  // delay slot and everything after it (including a same-cycle push) is dropped.
  assign keep_queued = branch_fire & (count_q >= CNT_W'(2));

  assign rd_next  = rd_ptr + PTR_W'(1);
  assign rd_next2 = rd_ptr + PTR_W'(2);
  assign wr_next  = wr_ptr + PTR_W'(1);

  // A push is stored unless flushed or squashed; on a branch with a lone head,
  // the pushed word is the delay slot itself.
  assign wr_en  = push_fire & ~bus.flush & ~keep_queued;
  assign wr_tag = branch_fire | ds_pending;

  assign bus.push_ready    = ~full;
  assign bus.pop_valid     = ~empty;
  assign bus.pop_addr      = empty ? '0 : addr_mem[rd_ptr];
  assign bus.pop_inst      = empty ? '0 : inst_mem[rd_ptr];
  assign bus.pop_delayslot = empty ? 1'b0 : tag_mem[rd_ptr];
  assign bus.count         = count_q;

  // Entry storage: write on accepted push, retag the surviving delay slot on a branch
  always_ff @(posedge clk) begin
    if (wr_en) begin
      addr_mem[wr_ptr] <= bus.push_addr;
      inst_mem[wr_ptr] <= bus.push_inst;
      tag_mem[wr_ptr]  <= wr_tag;
    end
    if (keep_queued) begin
      tag_mem[rd_next] <= 1'b1;
    end
  end

  // Pointers, occupancy and the pending delay-slot flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      ds_pending <= 1'b0;
    end else if (bus.flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      ds_pending <= 1'b0;
    end else if (branch_fire) begin
      rd_ptr <= rd_next;
      if (keep_queued) begin
        wr_ptr  <= rd_next2;
        count_q <= CNT_W'(1);
      end else if (push_fire) begin
        wr_ptr     <= wr_next;
        count_q    <= CNT_W'(1);
        ds_pending <= 1'b0;
      end else begin
        count_q    <= '0;
        ds_pending <= 1'b1;
      end
    end else begin
      if (push_fire) begin
        wr_ptr     <= wr_next;
        ds_pending <= 1'b0;
      end
      if (pop_fire) begin
        rd_ptr <= rd_next;
      end
      if (push_fire && !pop_fire) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!push_fire && pop_fire) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_id_inst_buffer.sv
// tb/tb_id_inst_buffer.sv - scoreboard bench for id_inst_buffer against a queue model
module tb_id_inst_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_inst_buffer_if #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32)) bus();

  id_inst_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic        ds;
  } ent_t;

  typedef struct {
    int          cnt;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        ds;
  } exp_t;

  ent_t model_q[$];
  exp_t exp_q[$];
  bit   ds_pend = 1'b0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare what the DUT presents against the expectation queued for this cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("count", 64'(bus.count), 64'(e.cnt));
      chk("push_ready", 64'(bus.push_ready), 64'(e.cnt != DEPTH));
      chk("pop_valid", 64'(bus.pop_valid), 64'(e.cnt != 0));
      chk("pop_addr", 64'(bus.pop_addr), 64'(e.addr));
      chk("pop_inst", 64'(bus.pop_inst), 64'(e.inst));
      chk("pop_delayslot", 64'(bus.pop_delayslot), 64'(e.ds));
    end
  end

  // One cycle of stimulus: drive inputs, queue the expected view, advance the model
  task automatic step(input bit fl, input bit pv, input logic [31:0] pa,
                      input logic [31:0] pi, input bit pr, input bit bt);
    exp_t e;
    ent_t n;
    ent_t keep;
    int   cnt;
    bit   pushf;
    bit   popf;
    @(posedge clk);
    #1;
    bus.flush        = fl;
    bus.push_valid   = pv;
    bus.push_addr    = pa;
    bus.push_inst    = pi;
    bus.pop_ready    = pr;
    bus.branch_taken = bt;

    cnt   = model_q.size();
    e.cnt = cnt;
    if (cnt > 0) begin
      e.addr = model_q[0].addr;
      e.inst = model_q[0].inst;
      e.ds   = model_q[0].ds;
    end else begin
      e.addr = '0;
      e.inst = '0;
      e.ds   = 1'b0;
    end
    exp_q.push_back(e);

    pushf  = pv && (cnt < DEPTH);
    popf   = pr && (cnt > 0);
    n.addr = pa;
    n.inst = pi;
    if (fl) begin
      model_q.delete();
      ds_pend = 1'b0;
    end else if (popf && bt) begin
      void'(model_q.pop_front());
      if (model_q.size() > 0) begin
        keep    = model_q[0];
        keep.ds = 1'b1;
        model_q.delete();
        model_q.push_back(keep);
      end else if (pushf) begin
        n.ds = 1'b1;
        model_q.push_back(n);
        ds_pend = 1'b0;
      end else begin
        ds_pend = 1'b1;
      end
    end else begin
      if (popf) void'(model_q.pop_front());
      if (pushf) begin
        n.ds = ds_pend;
        model_q.push_back(n);
        ds_pend = 1'b0;
      end
    end
  endtask

  task automatic push_pc(input logic [31:0] a, input bit pr);
    step(1'b0, 1'b1, a, $urandom, pr, 1'b0);
  endtask

  task automatic pop_one(input bit bt);
    step(1'b0, 1'b0, '0, '0, 1'b1, bt);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  bit r_fl;
  bit r_pv;
  bit r_pr;
  bit r_bt;

  initial begin
    bus.flush        = 1'b0;
    bus.push_valid   = 1'b0;
    bus.push_addr    = '0;
    bus.push_inst    = '0;
    bus.pop_ready    = 1'b0;
    bus.branch_taken = 1'b0;
    #1;
    chk("reset_count", 64'(bus.count), 64'd0);
    chk("reset_push_ready", 64'(bus.push_ready), 64'd1);
    chk("reset_pop_valid", 64'(bus.pop_valid), 64'd0);
    chk("reset_pop_inst", 64'(bus.pop_inst), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill, refused fifth push, drain
    for (int i = 0; i < 5; i++) push_pc(32'(i * 4), 1'b0);
    idle();
    for (int i = 0; i < 5; i++) pop_one(1'b0);
    idle();

    // Stall hold
    push_pc(32'h10, 1'b0);
    repeat (3) idle();
    pop_one(1'b0);
    idle();

    // Branch with the delay slot already queued
    for (int i = 0; i < 4; i++) push_pc(32'h20 + 32'(i * 4), 1'b0);
    step(1'b0, 1'b1, 32'h30, $urandom, 1'b1, 1'b1);
    push_pc(32'h100, 1'b1);
    pop_one(1'b0);
    idle();

    // Branch with empty tail
    push_pc(32'h40, 1'b0);
    pop_one(1'b1);
    idle();
    push_pc(32'h44, 1'b0);
    push_pc(32'h200, 1'b1);
    pop_one(1'b0);
    idle();

    // Branch on a lone head with a same-cycle push
    push_pc(32'h50, 1'b0);
    step(1'b0, 1'b1, 32'h54, $urandom, 1'b1, 1'b1);
    push_pc(32'h400, 1'b1);
    pop_one(1'b0);
    idle();

    // Flush priority
    for (int i = 0; i < 3; i++) push_pc(32'h60 + 32'(i * 4), 1'b0);
    step(1'b1, 1'b1, 32'h6C, $urandom, 1'b1, 1'b1);
    push_pc(32'h300, 1'b0);
    pop_one(1'b0);
    idle();

    // Pointer wrap with back-to-back push/pop
    push_pc(32'h1000, 1'b0);
    for (int i = 1; i <= 10; i++) push_pc(32'h1000 + 32'(i * 4), 1'b1);
    pop_one(1'b0);
    idle();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      r_fl = ($urandom_range(0, 39) == 0);
      r_pv = ($urandom_range(0, 3) != 0);
      r_pr = ($urandom_range(0, 2) != 0);
      r_bt = ($urandom_range(0, 4) == 0) && (model_q.size() > 0) && !model_q[0].ds;
      step(r_fl, r_pv, {$urandom_range(0, 16'hFFFF), 2'b00}, $urandom, r_pr, r_bt);
    end

    // Asynchronous reset between clock edges
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    push_pc(32'h500, 1'b0);
    push_pc(32'h504, 1'b0);
    idle();
    @(negedge clk);
    #1;
    chk("pre_reset_pop_valid", 64'(bus.pop_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_reset_pop_valid", 64'(bus.pop_valid), 64'd0);
    chk("async_reset_count", 64'(bus.count), 64'd0);
    chk("async_reset_pop_addr", 64'(bus.pop_addr), 64'd0);
    chk("async_reset_push_ready", 64'(bus.push_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
